// File: rtl/wsp_pkg.sv
// Shared encodings for the s349 P1500 wrapper serial port decode.
// Instruction codes, phase encoding and the default WIR width.
package wsp_pkg;

    localparam int WSP_IR_W = 3;

    localparam logic [2:0] WS_BYPASS  = 3'b000;
    localparam logic [2:0] WS_EXTEST  = 3'b001;
    localparam logic [2:0] WS_INTEST  = 3'b010;
    localparam logic [2:0] WS_PRELOAD = 3'b011;
    localparam logic [2:0] WS_CLAMP   = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAPT = 2'd1,
        ST_SHFT = 2'd2,
        ST_UPDT = 2'd3
    } wsp_state_e;

endpackage

// File: rtl/wsp_wby_cell.sv
// WBY bypass register: one flop that clears on capture and loads
// the serial input on shift.
module wsp_wby_cell (
    input  logic WRCK,
    input  logic WRSTN,
    input  logic cap_en,
    input  logic shift_en,
    input  logic si,
    output logic q
);

    always_ff @(posedge WRCK or negedge WRSTN) begin
        if (!WRSTN) begin
            q <= 1'b0;
        end else if (cap_en) begin
            q <= 1'b0;
        end else if (shift_en) begin
            q <= si;
        end
    end

endmodule

// File: rtl/wsp_instr_decode.sv
// WIR instruction decode, WSP phase tracking and WSO muxing for s349.
// Build with WSP_CLAMP_EN defined to make code 100 a legal WS_CLAMP.
module wsp_instr_decode
    import wsp_pkg::*;
#(
    parameter int IR_W   = WSP_IR_W,
    parameter int SCNT_W = 8
) (
    input  logic              WRCK,
    input  logic              WRSTN,
    input  logic              SelectWIR,
    input  logic              CaptureWR,
    input  logic              ShiftWR,
    input  logic              UpdateWR,
    input  logic              WSI,
    input  logic [IR_W-1:0]   wir_q,
    input  logic              wir_so,
    input  logic              wbr_so,
    output logic              WSO,
    output logic              wbr_capture,
    output logic              wbr_shift,
    output logic              wbr_update,
    output logic              wbr_ext,
    output logic              wbr_int,
    output logic [SCNT_W-1:0] shift_cnt,
    output logic              seq_err
);

    logic            upd_d;
    logic [IR_W-1:0] ir_q;
    logic            byp_q;
    logic            clamp_q;
    logic            ext_q;
    logic            int_q;
    logic            err_q;
    logic            wby_q;
    wsp_state_e      state;
    logic [SCNT_W-1:0] cnt_q;

    logic d_byp;
    logic d_clamp;
    logic d_ext;
    logic d_int;
    logic d_ill;

    always_comb begin
        d_byp   = 1'b0;
        d_clamp = 1'b0;
        d_ext   = 1'b0;
        d_int   = 1'b0;
        d_ill   = 1'b0;
        unique case (1'b1)
            (ir_q == IR_W'(WS_BYPASS)):  d_byp = 1'b1;
            (ir_q == IR_W'(WS_EXTEST)):  d_ext = 1'b1;
            (ir_q == IR_W'(WS_INTEST)):  d_int = 1'b1;
            (ir_q == IR_W'(WS_PRELOAD)): d_ext = 1'b0;
`ifdef WSP_CLAMP_EN
            (ir_q == IR_W'(WS_CLAMP)): begin
                d_clamp = 1'b1;
                d_ext   = 1'b1;
            end
`endif
            default: begin
                d_byp = 1'b1;
                d_ill = 1'b1;
            end
        endcase
    end

    logic multi;
    logic dr_op;
    logic wby_act;
    logic wbr_ok;
    logic idle_shift;

    // Any two strobes at once is a protocol violation: everything holds.
    assign multi      = (CaptureWR & ShiftWR) | (CaptureWR & UpdateWR)
                      | (ShiftWR & UpdateWR);
    assign dr_op      = ~SelectWIR & ~multi;
    assign wby_act    = byp_q | clamp_q;
    assign wbr_ok     = dr_op & ~wby_act;
    assign idle_shift = dr_op & ShiftWR & (state == ST_IDLE);

    assign wbr_capture = CaptureWR & wbr_ok;
    assign wbr_shift   = ShiftWR & wbr_ok & (state != ST_IDLE);
    assign wbr_update  = UpdateWR & wbr_ok;
    assign wbr_ext     = ext_q;
    assign wbr_int     = int_q;
    assign shift_cnt   = cnt_q;
    assign seq_err     = err_q;

    assign WSO = SelectWIR ? wir_so : (wby_act ? wby_q : wbr_so);

    wsp_wby_cell u_wby (
        .WRCK     (WRCK),
        .WRSTN    (WRSTN),
        .cap_en   (CaptureWR & dr_op & wby_act),
        .shift_en (ShiftWR & dr_op & wby_act),
        .si       (WSI),
        .q        (wby_q)
    );

    always_ff @(posedge WRCK or negedge WRSTN) begin
        if (!WRSTN) begin
            upd_d   <= 1'b0;
            ir_q    <= IR_W'(WS_BYPASS);
            byp_q   <= 1'b1;
            clamp_q <= 1'b0;
            ext_q   <= 1'b0;
            int_q   <= 1'b0;
            err_q   <= 1'b0;
            state   <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            upd_d <= UpdateWR & SelectWIR;
            if (upd_d) begin
                ir_q <= wir_q;
            end
            byp_q   <= d_byp;
            clamp_q <= d_clamp;
            ext_q   <= d_ext;
            int_q   <= d_int;
            if (multi | idle_shift | d_ill) begin
                err_q <= 1'b1;
            end
            if (dr_op) begin
                unique case (state)
                    ST_IDLE: begin
                        if (CaptureWR) begin
                            state <= ST_CAPT;
                            cnt_q <= '0;
                        end else if (UpdateWR) begin
                            state <= ST_UPDT;
                        end
                    end
                    ST_CAPT, ST_SHFT: begin
                        if (UpdateWR) begin
                            state <= ST_UPDT;
                        end else if (ShiftWR) begin
                            state <= ST_SHFT;
                            if (!(&cnt_q)) begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
                    ST_UPDT: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wsp_instr_decode.sv
// Directed plus randomized bench for wsp_instr_decode against a
// cycle-level behavioural model of the wrapper serial port.
module tb_wsp_instr_decode;

`ifdef WSP_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif
    localparam int CNT_MAX = 255;

    logic       WRCK = 1'b0;
    logic       WRSTN = 1'b0;
    logic       SelectWIR = 1'b0;
    logic       CaptureWR = 1'b0;
    logic       ShiftWR = 1'b0;
    logic       UpdateWR = 1'b0;
    logic       WSI = 1'b0;
    logic [2:0] wir_q = 3'b000;
    logic       wir_so = 1'b0;
    logic       wbr_so = 1'b0;
    logic       WSO;
    logic       wbr_capture;
    logic       wbr_shift;
    logic       wbr_update;
    logic       wbr_ext;
    logic       wbr_int;
    logic [7:0] shift_cnt;
    logic       seq_err;

    wsp_instr_decode #(.IR_W(3), .SCNT_W(8)) dut (
        .WRCK        (WRCK),
        .WRSTN       (WRSTN),
        .SelectWIR   (SelectWIR),
        .CaptureWR   (CaptureWR),
        .ShiftWR     (ShiftWR),
        .UpdateWR    (UpdateWR),
        .WSI         (WSI),
        .wir_q       (wir_q),
        .wir_so      (wir_so),
        .wbr_so      (wbr_so),
        .WSO         (WSO),
        .wbr_capture (wbr_capture),
        .wbr_shift   (wbr_shift),
        .wbr_update  (wbr_update),
        .wbr_ext     (wbr_ext),
        .wbr_int     (wbr_int),
        .shift_cnt   (shift_cnt),
        .seq_err     (seq_err)
    );

    always #5 WRCK = ~WRCK;

    int checks = 0;
    int failures = 0;

    // Model: phase 0=idle 1=capture 2=shift 3=update; mode is the
    // effective instruction code (illegal codes fold to bypass).
    int m_upd, m_ir, m_mode, m_phase, m_cnt, m_err, m_wby;

    function automatic bit legal(int code);
        return (code <= 3) || (CLAMP_EN && code == 4);
    endfunction

    function automatic bit bypass_like(int mode);
        return (mode == 0) || (mode == 4);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_upd = 0; m_ir = 0; m_mode = 0; m_phase = 0;
        m_cnt = 0; m_err = 0; m_wby = 0;
    endtask

    task automatic check_all(string tag);
        int  n;
        bit  dr;
        bit  bl;
        n  = int'(CaptureWR) + int'(ShiftWR) + int'(UpdateWR);
        dr = !SelectWIR && n < 2;
        bl = bypass_like(m_mode);
        chk({tag, ":cap"}, 32'(wbr_capture), 32'(CaptureWR && dr && !bl));
        chk({tag, ":shf"}, 32'(wbr_shift),
            32'(ShiftWR && dr && !bl && m_phase != 0));
        chk({tag, ":upd"}, 32'(wbr_update), 32'(UpdateWR && dr && !bl));
        chk({tag, ":ext"}, 32'(wbr_ext), 32'(m_mode == 1 || m_mode == 4));
        chk({tag, ":int"}, 32'(wbr_int), 32'(m_mode == 2));
        chk({tag, ":wso"}, 32'(WSO),
            32'(SelectWIR ? wir_so : (bl ? m_wby[0] : wbr_so)));
        chk({tag, ":cnt"}, 32'(shift_cnt), 32'(m_cnt));
        chk({tag, ":err"}, 32'(seq_err), 32'(m_err));
    endtask

    task automatic model_edge();
        int n;
        bit dr;
        bit bl;
        int nmode;
        n  = int'(CaptureWR) + int'(ShiftWR) + int'(UpdateWR);
        dr = !SelectWIR && n < 2;
        bl = bypass_like(m_mode);
        if (n >= 2 || !legal(m_ir) || (dr && ShiftWR && m_phase == 0))
            m_err = 1;
        nmode = legal(m_ir) ? m_ir : 0;
        if (m_upd != 0) m_ir = int'(wir_q);
        m_upd  = int'(UpdateWR && SelectWIR);
        m_mode = nmode;
        if (dr && bl) begin
            if (CaptureWR) m_wby = 0;
            else if (ShiftWR) m_wby = int'(WSI);
        end
        if (dr) begin
            case (m_phase)
                0: if (CaptureWR) begin m_phase = 1; m_cnt = 0; end
                   else if (UpdateWR) m_phase = 3;
                1, 2: if (UpdateWR) m_phase = 3;
                      else if (ShiftWR) begin
                          m_phase = 2;
                          if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
                      end
                default: m_phase = 0;
            endcase
        end
    endtask

    // Called in the low phase; returns at the next falling edge.
    task automatic step(string tag, bit c, bit s, bit u, bit sel,
                        bit wsi, logic [2:0] wq);
        CaptureWR = c; ShiftWR = s; UpdateWR = u; SelectWIR = sel;
        WSI = wsi; wir_q = wq;
        wir_so = 1'($urandom); wbr_so = 1'($urandom);
        #2;
        check_all(tag);
        @(posedge WRCK);
        model_edge();
        @(negedge WRCK);
    endtask

    task automatic do_reset(string tag);
        CaptureWR = 0; ShiftWR = 0; UpdateWR = 0; SelectWIR = 0;
        WSI = 0;
        WRSTN = 1'b0;
        #2;
        model_reset();
        check_all(tag);
        @(negedge WRCK);
        WRSTN = 1'b1;
    endtask

    task automatic load_ir(string tag, logic [2:0] code);
        step(tag, 0, 0, 1, 1, 0, code);
        step(tag, 0, 0, 0, 1, 0, code);
        step(tag, 0, 0, 0, 1, 0, code);
    endtask

    initial begin
        bit wpat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        int k;
        model_reset();
        do_reset("reset");

        for (int i = 0; i < 4; i++) step("byp_shift", 0, 1, 0, 0, wpat[i], 3'd0);
        step("byp_idle", 0, 0, 0, 0, 0, 3'd0);

        load_ir("ld_ext", 3'd1);
        chk("ext_on", 32'(wbr_ext), 32'd1);
        step("ext_cap", 1, 0, 0, 0, 0, 3'd1);
        for (int i = 0; i < 5; i++) step("ext_shf", 0, 1, 0, 0, 1'($urandom), 3'd1);
        step("ext_upd", 0, 0, 1, 0, 0, 3'd1);
        chk("ext_cnt5", 32'(shift_cnt), 32'd5);
        step("ext_post", 0, 0, 0, 0, 0, 3'd1);
        step("ext_post", 0, 0, 0, 0, 0, 3'd1);

        step("idle_shf", 0, 1, 0, 0, 1, 3'd1);
        step("multi", 1, 1, 0, 0, 1, 3'd1);
        step("after_multi", 0, 0, 0, 0, 0, 3'd1);
        chk("err_sticky", 32'(seq_err), 32'd1);

        do_reset("rst_ill");
        load_ir("ld_111", 3'd7);
        chk("ill_err", 32'(seq_err), 32'd1);
        step("ill_shf", 0, 1, 0, 0, 1, 3'd7);

        do_reset("rst_clamp");
        load_ir("ld_100", 3'd4);
        chk("clamp_ext", 32'(wbr_ext), 32'(CLAMP_EN));
        step("clamp_cap", 1, 0, 0, 0, 0, 3'd4);
        step("clamp_shf", 0, 1, 0, 0, 1, 3'd4);
        step("clamp_upd", 0, 0, 1, 0, 0, 3'd4);
        step("clamp_idle", 0, 0, 0, 0, 0, 3'd4);

        load_ir("ld_int", 3'd2);
        step("int_cap", 1, 0, 0, 0, 0, 3'd2);
        for (int i = 0; i < 3; i++) step("int_shf", 0, 1, 0, 0, 1, 3'd2);
        chk("mid_cnt3", 32'(shift_cnt), 32'd3);
        do_reset("rst_mid");
        step("post_cap", 1, 0, 0, 0, 0, 3'd2);
        step("post_shf", 0, 1, 0, 0, 1, 3'd2);
        step("post_shf", 0, 1, 0, 0, 0, 3'd2);

        do_reset("rst_sat");
        step("sat_cap", 1, 0, 0, 0, 0, 3'd0);
        for (int i = 0; i < 300; i++) step("sat_shf", 0, 1, 0, 0, 1'($urandom), 3'd0);
        chk("sat_255", 32'(shift_cnt), 32'd255);

        do_reset("rst_rand");
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset("rand_rst");
            k = $urandom_range(0, 9);
            step("rand",
                 k == 3 || k == 8,
                 (k >= 4 && k <= 6) || (k == 8 && 1'($urandom)),
                 k == 7 || k == 9,
                 $urandom_range(0, 5) == 0,
                 1'($urandom),
                 3'($urandom_range(0, 7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
